branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles flush is held after a redirect (range 1..7).
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port advance, input, 1: pipeline moves one stage when 1 and holds when 0.
REQ-006 SHALL have port f_valid, input, 1: fetch slot holds a real instruction.
REQ-007 SHALL have port f_pc, input, 32: fetch PC.
REQ-008 SHALL have port f_pred_taken, input, 1: predictor's taken prediction for f_pc.
REQ-009 SHALL have port f_pred_target, input, 32: predicted target; only meaningful when f_pred_taken=1.
REQ-010 SHALL have port ex_opcode, input, 7: opcode of the instruction in EX.
REQ-011 SHALL have port br_en, input, 1: actual branch outcome in EX.
REQ-012 SHALL have port ex_target, input, 32: actual taken target in EX.
REQ-013 SHALL have port upd_valid, output, 1: one-cycle predictor update strobe.
REQ-014 SHALL have port upd_pc, output, 32: PC of the resolved branch.
REQ-015 SHALL have port upd_taken, output, 1: actual outcome being reported.
REQ-016 SHALL have port redirect, output, 1: one-cycle fetch redirect pulse.
REQ-017 SHALL have port redirect_pc, output, 32: correct next PC.
REQ-018 SHALL have port flush, output, 1: kill signal for younger instructions.
REQ-019 SHALL have port br_cnt, output, CNT_W: count of resolved conditional branches.
REQ-020 SHALL have port mp_cnt, output, CNT_W: count of mispredicts.

Function
REQ-021 SHALL carry {valid, pc, pred_taken, pred_target} through a DEC slot and then an EX slot, both loaded only when advance=1.
REQ-022 SHALL load the DEC slot with valid=0 (bubble) while flush=1.
REQ-023 SHALL resolve EX slot combinationally when EX valid=1 and advance=1; all outputs registered, latency 1 cycle.
REQ-024 SHALL treat opcode 7'b1100011 (BR) as conditional: upd_valid=1, upd_pc=EX pc, upd_taken=br_en, br_cnt increments.
REQ-025 SHALL flag BR mispredict iff pred_taken!=br_en, or pred_taken=br_en=1 with pred_target!=ex_target.
REQ-026 SHALL flag JAL (1101111)/JALR (1100111) mispredict iff pred_taken=0 or pred_target!=ex_target; no upd_valid, no br_cnt increment.
REQ-027 SHALL set redirect_pc on mispredict to ex_target if taken, else EX pc+4 (mod 2^32).
REQ-028 SHALL on mispredict pulse redirect for 1 cycle, increment mp_cnt, and enter FLUSH.
REQ-029 SHALL use FSM IDLE/FLUSH: IDLE->FLUSH on mispredict; FLUSH holds flush=1 for exactly FLUSH_CYCLES cycles regardless of advance; FLUSH->IDLE when the down-counter reaches 0.
REQ-030 SHALL invalidate the EX slot in the same cycle as the mispredict so a second redirect cannot occur from a wrong-path slot; resolutions in FLUSH are suppressed.
REQ-031 SHALL saturate both counters at all-ones.
REQ-032 SHALL treat a non-branch opcode or EX valid=0 as a no-op: all strobes 0.
REQ-033 SHALL freeze slots, strobes and counters when advance=0; FSM count still decrements.

Reset
REQ-034 SHALL on rst clear both slots valid=0, FSM=IDLE, counters=0, upd_valid=redirect=flush=0, upd_pc=redirect_pc=0, upd_taken=0.
REQ-035 SHALL let rst mid-FLUSH drop flush on the next cycle.

Structure
REQ-036 SHALL put opcode constants, the brs_state_t enum {IDLE, FLUSH} and the pred_meta_t struct in shared package branch_pkg.
REQ-037 SHALL implement the DEC and EX slots as two instances of sub-module pred_meta_reg (enable, clear, pred_meta_t in/out).

Verification
REQ-038 SHALL cover: BR pc=0x100 pred NT, br_en=0 -> upd_valid, upd_taken=0, no redirect, br_cnt=1.
REQ-039 SHALL cover: BR pc=0x200 pred NT, br_en=1, ex_target=0x240 -> redirect_pc=0x240, flush high 2 cycles, mp_cnt=1.
REQ-040 SHALL cover: BR pc=0x300 pred T target 0x310, actual T to 0x320 -> mispredict, redirect_pc=0x320.
REQ-041 SHALL cover: JAL pc=0x400 pred T 0x500 correct -> no upd_valid, no redirect; second case pred NT -> redirect 0x500.
REQ-042 SHALL cover: mispredict followed by a wrong-path BR reaching EX within the flush window -> single redirect only.
REQ-043 SHALL cover: advance=0 for 3 cycles with a BR in EX -> outputs held, then resolves once; rst during FLUSH -> flush=0 the next cycle.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for branch resolution: opcodes, FSM states and the per-slot prediction metadata.
package branch_pkg;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } brs_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } pred_meta_t;
endpackage

// File: rtl/pred_meta_reg.sv
// One pipeline slot of prediction metadata; 1-cycle load when en_i, clr_i wins and zeroes the slot.
// No backpressure of its own: the slot holds whenever en_i is low.
module pred_meta_reg
    import branch_pkg::*;
(
    input  logic       clk,
    input  logic       en_i,
    input  logic       clr_i,
    input  pred_meta_t d_i,
    output pred_meta_t q_o
);
    pred_meta_t meta_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            meta_q <= '0;
        end else if (en_i) begin
            meta_q <= d_i;
        end
    end

    assign q_o = meta_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in EX against the fetch-time prediction; all outputs registered, 1-cycle latency.
// advance=0 freezes slots, strobes and counters; only the flush down-counter keeps running.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic             f_pred_taken,
    input  logic [31:0]      f_pred_target,
    input  logic [6:0]       ex_opcode,
    input  logic             br_en,
    input  logic [31:0]      ex_target,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt
);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    pred_meta_t dec_d, dec_q, ex_q;
    brs_state_t state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic       in_flush, resolve, is_br, is_jmp, act_taken, mispredict, slot_clr;

    logic             upd_valid_q, upd_taken_q, redirect_q;
    logic [31:0]      upd_pc_q, redirect_pc_q;
    logic [CNT_W-1:0] br_cnt_q, mp_cnt_q;

    assign in_flush = (state_q == FLUSH);

    always_comb begin
        dec_d             = '0;
        dec_d.valid       = f_valid & ~in_flush;
        dec_d.pc          = f_pc;
        dec_d.pred_taken  = f_pred_taken;
        dec_d.pred_target = f_pred_target;
    end

    // Both slots are wiped on a mispredict so wrong-path work can never resolve later.
    assign slot_clr = rst | mispredict;

    pred_meta_reg u_dec_slot (
        .clk   (clk),
        .en_i  (advance),
        .clr_i (slot_clr),
        .d_i   (dec_d),
        .q_o   (dec_q)
    );

    pred_meta_reg u_ex_slot (
        .clk   (clk),
        .en_i  (advance),
        .clr_i (slot_clr),
        .d_i   (dec_q),
        .q_o   (ex_q)
    );

    assign resolve   = advance & ex_q.valid & ~in_flush;
    assign is_br     = (ex_opcode == OP_BR);
    assign is_jmp    = (ex_opcode == OP_JAL) | (ex_opcode == OP_JALR);
    assign act_taken = is_br ? br_en : 1'b1;
    assign mispredict = resolve & (is_br | is_jmp) &
                        ((ex_q.pred_taken != act_taken) |
                         (act_taken & (ex_q.pred_target != ex_target)));

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= 32'd0;
            upd_taken_q   <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            br_cnt_q      <= '0;
            mp_cnt_q      <= '0;
        end else if (advance) begin
            upd_valid_q <= resolve & is_br;
            redirect_q  <= mispredict;
            if (resolve & is_br) begin
                upd_pc_q    <= ex_q.pc;
                upd_taken_q <= br_en;
                if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (mispredict) begin
                redirect_pc_q <= act_taken ? ex_target : ex_q.pc + 32'd4;
                if (mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
            end
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_taken   = upd_taken_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = in_flush;
    assign br_cnt      = br_cnt_q;
    assign mp_cnt      = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scenarios followed by random traffic, every cycle compared against a behavioural model.
module tb_branch_resolve_unit;
    localparam int FC = 2;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, NOP = 7'h13;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, advance, f_valid, f_pred_taken, br_en;
    logic [31:0] f_pc, f_pred_target, ex_target;
    logic [6:0]  ex_opcode;
    logic        upd_valid, upd_taken, redirect, flush;
    logic [31:0] upd_pc, redirect_pc, br_cnt, mp_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .advance(advance), .f_valid(f_valid), .f_pc(f_pc),
        .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target), .ex_opcode(ex_opcode),
        .br_en(br_en), .ex_target(ex_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
    );

    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        pt;
        bit [31:0] tgt;
    } slot_t;

    slot_t     m_dec, m_ex;
    int        m_flush_left;
    bit        m_uv, m_ut, m_rd;
    bit [31:0] m_upc, m_rpc;
    longint    m_br, m_mp;
    int        n_chk = 0, n_fail = 0, n_redir;

    // Instruction age model: a redirect throws away everything younger and opens a flush window.
    function automatic void model_edge();
        bit flushing, cond, jump, taken, live, wrong;
        if (rst) begin
            m_dec = '{0, 0, 0, 0}; m_ex = '{0, 0, 0, 0};
            m_flush_left = 0; m_uv = 0; m_ut = 0; m_rd = 0;
            m_upc = 0; m_rpc = 0; m_br = 0; m_mp = 0;
            return;
        end
        flushing = (m_flush_left > 0);
        cond  = (ex_opcode == BR);
        jump  = (ex_opcode == JAL) || (ex_opcode == JALR);
        taken = jump ? 1'b1 : br_en;
        live  = advance && m_ex.v && !flushing && (cond || jump);
        wrong = live && ((m_ex.pt != taken) || (taken && (m_ex.tgt != ex_target)));
        if (advance) begin
            m_uv = live && cond;
            m_rd = wrong;
            if (live && cond) begin
                m_upc = m_ex.pc;
                m_ut  = br_en;
                if (m_br < CNT_MAX) m_br++;
            end
            if (wrong) begin
                m_rpc = taken ? ex_target : m_ex.pc + 32'd4;
                if (m_mp < CNT_MAX) m_mp++;
                m_ex.v  = 0;
                m_dec.v = 0;
            end else begin
                m_ex  = m_dec;
                m_dec = '{f_valid && !flushing, f_pc, f_pred_taken, f_pred_target};
            end
        end
        if (flushing) m_flush_left--;
        if (wrong) m_flush_left = FC;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("upd_valid",   64'(upd_valid),   64'(m_uv));
        chk("upd_pc",      64'(upd_pc),      64'(m_upc));
        chk("upd_taken",   64'(upd_taken),   64'(m_ut));
        chk("redirect",    64'(redirect),    64'(m_rd));
        chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
        chk("flush",       64'(flush),       64'(m_flush_left > 0));
        chk("br_cnt",      64'(br_cnt),      64'(m_br));
        chk("mp_cnt",      64'(mp_cnt),      64'(m_mp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        advance = 1; f_valid = 0; ex_opcode = NOP;
        repeat (n) step();
    endtask

    task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                         input logic [6:0] op, input logic en, input logic [31:0] tgt);
        advance = 1; ex_opcode = NOP;
        f_valid = 1; f_pc = pc; f_pred_taken = pt; f_pred_target = ptgt;
        step();
        f_valid = 0;
        step();
        ex_opcode = op; br_en = en; ex_target = tgt;
        step();
        ex_opcode = NOP;
    endtask

    function automatic logic [31:0] pick_tgt();
        return ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h2000;
    endfunction

    initial begin
        rst = 1; advance = 0; f_valid = 0; f_pc = 0; f_pred_taken = 0; f_pred_target = 0;
        ex_opcode = NOP; br_en = 0; ex_target = 0;
        step(); step();
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        rst = 0;
        idle(2);

        // Correctly predicted not-taken conditional branch
        issue(32'h100, 0, 32'h0, BR, 0, 32'h180);
        chk("s1_upd_valid", 64'(upd_valid), 64'd1);
        chk("s1_upd_taken", 64'(upd_taken), 64'd0);
        chk("s1_upd_pc", 64'(upd_pc), 64'h100);
        chk("s1_redirect", 64'(redirect), 64'd0);
        chk("s1_br_cnt", 64'(br_cnt), 64'd1);

        // Direction mispredict and flush window length
        issue(32'h200, 0, 32'h0, BR, 1, 32'h240);
        chk("s2_redirect", 64'(redirect), 64'd1);
        chk("s2_redirect_pc", 64'(redirect_pc), 64'h240);
        chk("s2_flush0", 64'(flush), 64'd1);
        chk("s2_mp_cnt", 64'(mp_cnt), 64'd1);
        step();
        chk("s2_redirect_pulse", 64'(redirect), 64'd0);
        chk("s2_flush1", 64'(flush), 64'd1);
        step();
        chk("s2_flush2", 64'(flush), 64'd0);

        // Target mispredict on a taken branch
        issue(32'h300, 1, 32'h310, BR, 1, 32'h320);
        chk("s3_redirect", 64'(redirect), 64'd1);
        chk("s3_redirect_pc", 64'(redirect_pc), 64'h320);
        idle(3);

        // JAL correct, then JAL predicted not-taken
        issue(32'h400, 1, 32'h500, JAL, 0, 32'h500);
        chk("s4_upd_valid", 64'(upd_valid), 64'd0);
        chk("s4_redirect", 64'(redirect), 64'd0);
        chk("s4_br_cnt", 64'(br_cnt), 64'd3);
        issue(32'h400, 0, 32'h0, JAL, 0, 32'h500);
        chk("s4b_redirect", 64'(redirect), 64'd1);
        chk("s4b_redirect_pc", 64'(redirect_pc), 64'h500);
        chk("s4b_mp_cnt", 64'(mp_cnt), 64'd3);
        idle(3);

        // Mispredict with wrong-path branches behind it, stalled through the flush window
        advance = 1; f_valid = 1; f_pred_taken = 0; f_pred_target = 0; f_pc = 32'h600; ex_opcode = NOP;
        step();
        f_pc = 32'h604;
        step();
        ex_opcode = BR; br_en = 1; ex_target = 32'h700; f_pc = 32'h608;
        step();
        chk("s5_redirect_pc", 64'(redirect_pc), 64'h700);
        n_redir = int'(redirect);
        advance = 0; f_valid = 0;
        repeat (3) step();
        advance = 1;
        repeat (4) begin
            step();
            n_redir += int'(redirect);
        end
        chk("s5_single_redirect", 64'(n_redir), 64'd1);
        chk("s5_mp_cnt", 64'(mp_cnt), 64'd4);
        idle(2);

        // Stall with a branch sitting in EX
        advance = 1; ex_opcode = NOP; f_valid = 1; f_pc = 32'h800; f_pred_taken = 0;
        step();
        f_valid = 0;
        step();
        ex_opcode = BR; br_en = 0; ex_target = 32'h900; advance = 0;
        repeat (3) step();
        chk("s6_held_upd_valid", 64'(upd_valid), 64'd0);
        chk("s6_held_br_cnt", 64'(br_cnt), 64'd4);
        advance = 1;
        step();
        chk("s6_upd_valid", 64'(upd_valid), 64'd1);
        chk("s6_upd_pc", 64'(upd_pc), 64'h800);
        step();
        chk("s6_once", 64'(br_cnt), 64'd5);
        ex_opcode = NOP;

        // Reset in the middle of a flush
        issue(32'hA00, 0, 32'h0, BR, 1, 32'hA40);
        chk("s7_flush", 64'(flush), 64'd1);
        rst = 1;
        step();
        chk("s7_rst_flush", 64'(flush), 64'd0);
        chk("s7_rst_br_cnt", 64'(br_cnt), 64'd0);
        rst = 0;
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            advance       = ($urandom_range(0, 3) != 0);
            f_valid       = $urandom_range(0, 1);
            f_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            f_pred_taken  = $urandom_range(0, 1);
            f_pred_target = pick_tgt();
            case ($urandom_range(0, 3))
                0:       ex_opcode = BR;
                1:       ex_opcode = JAL;
                2:       ex_opcode = JALR;
                default: ex_opcode = 7'($urandom());
            endcase
            br_en     = $urandom_range(0, 1);
            ex_target = pick_tgt();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
